vga_sincronismo: RTL and testbench

- Generates the 640x480 @ 60 Hz VGA timing that drives every ship-drawing stage.
- Divides the system clock down to a pixel-rate tick.
- Runs horizontal and vertical counters and produces hsync, vsync, areaAtiva and the current linha/coluna.
- Sits directly upstream of the ship renderers (submarino, cruzador, hidroaviao, encouracado, porta-avioes) and of the board-level sync pins.

---
 rtl/vga_sincronismo.sv | 96 +++++++++
 tb/tb_vga_sincronismo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_sincronismo.sv
// 640x480@60 VGA timing generator: pixel-rate divider, h/v raster counters,
// and registered sync/blanking/position outputs all aligned to the same edge.
module vga_sincronismo #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIVEL = 640,
  parameter int unsigned H_FRENTE  = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_TRAS    = 48,
  parameter int unsigned V_VISIVEL = 480,
  parameter int unsigned V_FRENTE  = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_TRAS    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       hsync,
  output logic       vsync,
  output logic       areaAtiva,
  output logic [9:0] coluna,
  output logic [9:0] linha,
  output logic       pixelTick,
  output logic       fimQuadro
);

  localparam int unsigned DIV_W   = 4;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned H_TOTAL = H_VISIVEL + H_FRENTE + H_SYNC + H_TRAS;
  localparam int unsigned V_TOTAL = V_VISIVEL + V_FRENTE + V_SYNC + V_TRAS;
  localparam int unsigned HS_INI  = H_VISIVEL + H_FRENTE;
  localparam int unsigned HS_FIM  = HS_INI + H_SYNC;
  localparam int unsigned VS_INI  = V_VISIVEL + V_FRENTE;
  localparam int unsigned VS_FIM  = VS_INI + V_SYNC;

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, area_q, area_d;
  logic             pixel_q, pixel_d, fim_q, fim_d;
  logic             tick_c;

  // Next-state: divider, raster counters, and outputs derived from the new position
  always_comb begin
    tick_c  = (div_q == DIV_W'(CLK_DIV - 1));
    div_d   = tick_c ? '0 : div_q + DIV_W'(1);
    h_d     = h_q;
    v_d     = v_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    area_d  = area_q;
    pixel_d = tick_c;
    fim_d   = 1'b0;
    if (tick_c) begin
      if (h_q == CNT_W'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
      end
      area_d  = (h_d < CNT_W'(H_VISIVEL)) && (v_d < CNT_W'(V_VISIVEL));
      hsync_d = !((h_d >= CNT_W'(HS_INI)) && (h_d < CNT_W'(HS_FIM)));
      vsync_d = !((v_d >= CNT_W'(VS_INI)) && (v_d < CNT_W'(VS_FIM)));
      fim_d   = (h_d == '0) && (v_d == '0);
    end
  end

  // Reset parks the raster on the last pixel so the first tick lands on (0,0)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      h_q     <= CNT_W'(H_TOTAL - 1);
      v_q     <= CNT_W'(V_TOTAL - 1);
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      area_q  <= 1'b0;
      pixel_q <= 1'b0;
      fim_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      area_q  <= area_d;
      pixel_q <= pixel_d;
      fim_q   <= fim_d;
    end
  end

  assign coluna    = h_q;
  assign linha     = v_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign areaAtiva = area_q;
  assign pixelTick = pixel_q;
  assign fimQuadro = fim_q;

endmodule

// File: tb/tb_vga_sincronismo.sv
// Directed bench: a shrunken raster (25x15, CLK_DIV=2) for whole-frame and reset
// behaviour, plus the default 800x525 raster at CLK_DIV=1 for one-line timing.
module tb_vga_sincronismo;

  logic       clk = 1'b0;
  logic       rst_a_n = 1'b0;
  logic       rst_b_n = 1'b0;
  logic       hs_a, vs_a, ar_a, pt_a, fq_a;
  logic [9:0] col_a, lin_a;
  logic       hs_b, vs_b, ar_b, pt_b, fq_b;
  logic [9:0] col_b, lin_b;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  // Small raster: H 16/2/4/3 = 25, V 8/2/2/3 = 15, hsync low 18..21, vsync low 10..11
  vga_sincronismo #(
    .CLK_DIV(2), .H_VISIVEL(16), .H_FRENTE(2), .H_SYNC(4), .H_TRAS(3),
    .V_VISIVEL(8), .V_FRENTE(2), .V_SYNC(2), .V_TRAS(3)
  ) dut_a (
    .clk(clk), .reset_n(rst_a_n), .hsync(hs_a), .vsync(vs_a), .areaAtiva(ar_a),
    .coluna(col_a), .linha(lin_a), .pixelTick(pt_a), .fimQuadro(fq_a)
  );

  vga_sincronismo #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .hsync(hs_b), .vsync(vs_b), .areaAtiva(ar_b),
    .coluna(col_b), .linha(lin_b), .pixelTick(pt_b), .fimQuadro(fq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Advance dut_a by n pixel ticks (two clks each)
  task automatic adv(input int n);
    step(2 * n);
  endtask

  task automatic chk_a(input string tag, input int c, input int l, input logic ar,
                       input logic hs, input logic vs, input logic pt, input logic fq);
    chk({tag, ".col"}, 32'(col_a), 32'(c));
    chk({tag, ".lin"}, 32'(lin_a), 32'(l));
    chk({tag, ".area"}, 32'(ar_a), 32'(ar));
    chk({tag, ".hs"}, 32'(hs_a), 32'(hs));
    chk({tag, ".vs"}, 32'(vs_a), 32'(vs));
    chk({tag, ".pt"}, 32'(pt_a), 32'(pt));
    chk({tag, ".fq"}, 32'(fq_a), 32'(fq));
  endtask

  task automatic chk_b(input string tag, input int c, input int l, input logic ar,
                       input logic hs, input logic pt, input logic fq);
    chk({tag, ".col"}, 32'(col_b), 32'(c));
    chk({tag, ".lin"}, 32'(lin_b), 32'(l));
    chk({tag, ".area"}, 32'(ar_b), 32'(ar));
    chk({tag, ".hs"}, 32'(hs_b), 32'(hs));
    chk({tag, ".pt"}, 32'(pt_b), 32'(pt));
    chk({tag, ".fq"}, 32'(fq_b), 32'(fq));
  endtask

  initial begin
    int clks, pts, hs_low, vs_low, area_bad, fqs;

    // ---- Default raster, CLK_DIV=1 ----
    step(3);
    chk_b("b_rst", 799, 524, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("b_rst.vs", 32'(vs_b), 32'd1);
    rst_b_n = 1'b1;
    step(1);
    chk_b("b_first", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1);
    chk_b("b_c1", 1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(638);
    chk_b("b_c639", 639, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1);
    chk_b("b_c640", 640, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(15);
    chk_b("b_c655", 655, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1);
    chk_b("b_c656", 656, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(95);
    chk_b("b_c751", 751, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    chk_b("b_c752", 752, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(47);
    chk_b("b_c799", 799, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1);
    chk_b("b_l1", 0, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    pts = 0;
    hs_low = 0;
    for (int i = 0; i < 800; i++) begin
      step(1);
      pts += int'(pt_b);
      hs_low += int'(!hs_b);
    end
    chk("b_line.pt_count", 32'(pts), 32'd800);
    chk("b_line.hs_low", 32'(hs_low), 32'd96);
    chk_b("b_l2", 0, 2, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_b_n = 1'b0;

    // ---- Small raster, CLK_DIV=2: reset and first update ----
    chk_a("a_rst", 24, 14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_a_n = 1'b1;
    step(1);
    chk_a("a_e1", 24, 14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_a("a_e2", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1);
    chk_a("a_e3", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_a("a_e4", 1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // One line: blanking and hsync window
    adv(14);  chk_a("a_c15", 15, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    adv(1);   chk_a("a_c16", 16, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    adv(1);   chk_a("a_c17", 17, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    adv(1);   chk_a("a_c18", 18, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    adv(3);   chk_a("a_c21", 21, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    adv(1);   chk_a("a_c22", 22, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    adv(2);   chk_a("a_c24", 24, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    adv(1);   chk_a("a_l1", 0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Vertical blanking and vsync window
    adv(165); chk_a("a_15_7", 15, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    adv(1);   chk_a("a_16_7", 16, 7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    adv(9);   chk_a("a_0_8", 0, 8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    adv(49);  chk_a("a_24_9", 24, 9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    adv(1);   chk_a("a_0_10", 0, 10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    adv(49);  chk_a("a_24_11", 24, 11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    adv(1);   chk_a("a_0_12", 0, 12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Wrap corner
    adv(74);  chk_a("a_24_14", 24, 14, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    adv(1);   chk_a("a_wrap", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Whole frame: period and per-frame pulse/sync totals
    clks = 0; pts = 0; hs_low = 0; vs_low = 0; area_bad = 0; fqs = 0;
    do begin
      step(1);
      clks++;
      pts += int'(pt_a);
      hs_low += int'(!hs_a);
      vs_low += int'(!vs_a);
      fqs += int'(fq_a);
      if (ar_a && (lin_a >= 10'd8 || col_a >= 10'd16)) area_bad++;
    end while (!fq_a && clks < 2000);
    chk("a_frame.clks", 32'(clks), 32'd750);
    chk("a_frame.fq_count", 32'(fqs), 32'd1);
    chk("a_frame.pt_count", 32'(pts), 32'd375);
    chk("a_frame.hs_low", 32'(hs_low), 32'd120);
    chk("a_frame.vs_low", 32'(vs_low), 32'd100);
    chk("a_frame.area_bad", 32'(area_bad), 32'd0);
    chk_a("a_frame_end", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Mid-frame asynchronous reset, applied between clk edges
    adv(162); chk_a("a_12_6", 12, 6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    #2 rst_a_n = 1'b0;
    #1 chk_a("a_async_rst", 24, 14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(2);
    rst_a_n = 1'b1;
    step(1);
    chk_a("a_re_e1", 24, 14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_a("a_re_e2", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
